// File: rtl/clock_enable_sequencer.sv
// Single-clock enable sequencer: synchronises the board reset, releases per-channel
// resets in a staggered order and generates run-time programmable enable strobes.
module clock_enable_sequencer #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int NUM_CH        = 4,
    parameter int DIV_W         = 16,
    parameter int DEF_DIV       = 10,
    parameter int RST_STAGGER   = 16,
    parameter int SYNC_STAGES   = 2,
    localparam int CH_W         = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] en_out,
    output logic [NUM_CH-1:0] rstb_out,
    output logic              locked
);

    localparam int STG_W = (RST_STAGGER > 1) ? $clog2(RST_STAGGER) : 1;
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(RST_STAGGER - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
        $error("NUM_CH must be in the range 2..16");
    end
    if (RST_STAGGER < 1) begin : g_bad_stagger
        $error("RST_STAGGER must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (CLK_FREQUENCY < 1) begin : g_bad_freq
        $error("CLK_FREQUENCY must be positive");
    end

    typedef enum logic [1:0] {RST, SEQ, RUN} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rstb_sync;
    logic [STG_W-1:0]       stag_cnt;
    logic                   pend_valid;
    logic [CH_W-1:0]        pend_ch;
    logic [DIV_W-1:0]       pend_div;
    logic [DIV_W-1:0]       cnt [NUM_CH];
    logic [DIV_W-1:0]       div [NUM_CH];
    logic [NUM_CH-1:0]      wrap;
    logic [NUM_CH-1:0]      apply;
    logic                   in_range;
    logic                   xfer;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rstb_sync = sync[SYNC_STAGES-1];
    assign in_range  = (32'(cfg_ch) < NUM_CH);
    assign xfer      = cfg_valid && cfg_ready;

    // A wrap is the last cycle of a period; ratios of 0 and 1 wrap every cycle.
    always_comb begin
        wrap  = '0;
        apply = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            wrap[k]  = rstb_out[k] && ((div[k] <= DIV_ONE) || (cnt[k] == div[k] - DIV_ONE));
            apply[k] = pend_valid && (pend_ch == CH_W'(k)) && wrap[k];
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= RST;
            stag_cnt   <= '0;
            rstb_out   <= '0;
            locked     <= 1'b0;
            cfg_ready  <= 1'b0;
            pend_valid <= 1'b0;
            pend_ch    <= '0;
            pend_div   <= '0;
        end else begin
            case (state)
                RST, SEQ: begin
                    if (rstb_sync) begin
                        state <= SEQ;
                        if (stag_cnt == STG_LAST) begin
                            stag_cnt <= '0;
                            rstb_out <= {rstb_out[NUM_CH-2:0], 1'b1};
                            if (rstb_out[NUM_CH-2]) begin
                                state     <= RUN;
                                locked    <= 1'b1;
                                cfg_ready <= 1'b1;
                            end
                        end else begin
                            stag_cnt <= stag_cnt + STG_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (|apply) begin
                        pend_valid <= 1'b0;
                        cfg_ready  <= 1'b1;
                    end else if (xfer) begin
                        pend_ch  <= cfg_ch;
                        pend_div <= cfg_div;
                        // Requests for channels that do not exist are swallowed.
                        if (in_range) begin
                            pend_valid <= 1'b1;
                            cfg_ready  <= 1'b0;
                        end
                    end
                end
                default: state <= RST;
            endcase
        end
    end

    // New ratios only take effect at a wrap, so no period is ever cut short.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            en_out <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k] <= '0;
                div[k] <= DIV_W'(DEF_DIV);
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                en_out[k] <= wrap[k];
                if (!rstb_out[k]) begin
                    cnt[k] <= '0;
                end else if (apply[k]) begin
                    div[k] <= pend_div;
                    cnt[k] <= '0;
                end else if (wrap[k]) begin
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + DIV_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_enable_sequencer.sv
// Bench for clock_enable_sequencer: a time-based reference model checked every cycle,
// plus directed scenarios with hand-computed edge numbers.
module tb_clock_enable_sequencer;

    localparam int NUM_CH      = 4;
    localparam int DIV_W       = 16;
    localparam int DEF_DIV     = 10;
    localparam int RST_STAGGER = 16;
    localparam int SYNC_STAGES = 2;
    localparam int CH_W        = 2;
    localparam int MAX_PRINT   = 40;

    logic              clk;
    logic              rstb;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] rstb_out;
    logic              locked;

    logic              cfg_valid3;
    logic              cfg_ready3;
    logic [1:0]        cfg_ch3;
    logic [DIV_W-1:0]  cfg_div3;
    logic [2:0]        en_out3;
    logic [2:0]        rstb_out3;
    logic              locked3;

    int n_checks = 0;
    int n_fail   = 0;

    int                ecount;
    int                div_m   [NUM_CH];
    int                start_m [NUM_CH];
    bit                pend_m;
    int                pend_ch_m;
    int                pend_div_m;
    bit                rdy_m;
    logic [NUM_CH-1:0] exp_en;
    logic [NUM_CH-1:0] exp_rst;
    logic              exp_locked;

    clock_enable_sequencer #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV),
        .RST_STAGGER(RST_STAGGER), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rstb(rstb), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .en_out(en_out),
        .rstb_out(rstb_out), .locked(locked)
    );

    clock_enable_sequencer #(
        .NUM_CH(3), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV),
        .RST_STAGGER(RST_STAGGER), .SYNC_STAGES(SYNC_STAGES)
    ) dut3 (
        .clk(clk), .rstb(rstb), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
        .cfg_ch(cfg_ch3), .cfg_div(cfg_div3), .en_out(en_out3),
        .rstb_out(rstb_out3), .locked(locked3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= MAX_PRINT)
                $display("[TB] FAIL %s @%0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    function automatic int rel_edge(input int k);
        return SYNC_STAGES + (k + 1) * RST_STAGGER;
    endfunction

    task automatic model_reset();
        ecount     = 0;
        pend_m     = 1'b0;
        pend_ch_m  = 0;
        pend_div_m = 0;
        rdy_m      = 1'b0;
        exp_en     = '0;
        exp_rst    = '0;
        exp_locked = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            div_m[k]   = DEF_DIV;
            start_m[k] = rel_edge(k);
        end
    endtask

    // Edge e produces a strobe when a whole number of periods has elapsed since the
    // channel's current period origin (its release, or the edge its ratio changed).
    task automatic model_step();
        int e;
        ecount++;
        e = ecount;
        for (int k = 0; k < NUM_CH; k++) begin
            exp_rst[k] = (e >= rel_edge(k));
            exp_en[k]  = (e > rel_edge(k)) &&
                         ((div_m[k] <= 1) || (((e - start_m[k]) % div_m[k]) == 0));
        end
        if (pend_m && exp_en[pend_ch_m]) begin
            div_m[pend_ch_m]   = pend_div_m;
            start_m[pend_ch_m] = e;
            pend_m             = 1'b0;
        end
        if (cfg_valid && rdy_m && (int'(cfg_ch) < NUM_CH)) begin
            pend_m     = 1'b1;
            pend_ch_m  = int'(cfg_ch);
            pend_div_m = int'(cfg_div);
        end
        exp_locked = (e >= rel_edge(NUM_CH - 1));
        rdy_m      = exp_locked && !pend_m;
    endtask

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            model_reset();
            #1;
        end else begin
            model_step();
            #1;
        end
        check_output("model_en_out",    32'(en_out),    32'(exp_en));
        check_output("model_rstb_out",  32'(rstb_out),  32'(exp_rst));
        check_output("model_locked",    32'(locked),    32'(exp_locked));
        check_output("model_cfg_ready", 32'(cfg_ready), 32'(rdy_m));
    end

    task automatic wait_pulse(input int k);
        for (int g = 0; g < 30; g++) begin
            @(negedge clk);
            if (en_out[k]) break;
        end
        check_output($sformatf("wait_pulse_ch%0d", k), 32'(en_out[k]), 32'd1);
    endtask

    task automatic send_cfg(input int ch, input int dv);
        for (int g = 0; g < 40; g++) begin
            if (cfg_ready) break;
            @(negedge clk);
        end
        check_output("send_cfg_ready", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(dv);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic apply_stimulus_release(input string tag);
        int rise_e    [NUM_CH];
        int first_en  [NUM_CH];
        int exp_rise  [NUM_CH] = '{18, 34, 50, 66};
        int exp_first [NUM_CH] = '{28, 44, 60, 76};
        int lock_e = -1;
        int rdy_e  = -1;
        int early  = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            rise_e[k]   = -1;
            first_en[k] = -1;
        end
        rstb = 1'b1;
        repeat (100) begin
            @(negedge clk);
            for (int k = 0; k < NUM_CH; k++) begin
                if (rstb_out[k] && rise_e[k] < 0) rise_e[k] = ecount;
                if (en_out[k] && first_en[k] < 0) first_en[k] = ecount;
                if (en_out[k] && !rstb_out[k]) early++;
            end
            if (locked && lock_e < 0) lock_e = ecount;
            if (cfg_ready && rdy_e < 0) rdy_e = ecount;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            check_output($sformatf("%s_rise_ch%0d", tag, k), 32'(rise_e[k]), 32'(exp_rise[k]));
            check_output($sformatf("%s_first_en_ch%0d", tag, k), 32'(first_en[k]), 32'(exp_first[k]));
        end
        check_output({tag, "_locked_edge"}, 32'(lock_e), 32'd66);
        check_output({tag, "_ready_edge"}, 32'(rdy_e), 32'd66);
        check_output({tag, "_en_before_release"}, 32'(early), 32'd0);
    endtask

    task automatic apply_stimulus_steady();
        int counts [NUM_CH];
        for (int k = 0; k < NUM_CH; k++) counts[k] = 0;
        repeat (200) begin
            @(negedge clk);
            for (int k = 0; k < NUM_CH; k++) if (en_out[k]) counts[k]++;
        end
        for (int k = 0; k < NUM_CH; k++)
            check_output($sformatf("steady_pulses_ch%0d", k), 32'(counts[k]), 32'd20);
    endtask

    task automatic apply_stimulus_reconfig();
        int p;
        int rel;
        int rdy_rel = -1;
        int pulses[$];
        wait_pulse(1);
        p = ecount;
        repeat (3) @(negedge clk);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_div   = 16'd4;
        @(negedge clk);
        cfg_valid = 1'b0;
        check_output("reconf_ready_drop", 32'(cfg_ready), 32'd0);
        repeat (20) begin
            @(negedge clk);
            rel = ecount - p;
            if (en_out[1]) pulses.push_back(rel);
            if (cfg_ready && rdy_rel < 0) rdy_rel = rel;
        end
        check_output("reconf_pulse_a", 32'((pulses.size() > 0) ? pulses[0] : -1), 32'd10);
        check_output("reconf_pulse_b", 32'((pulses.size() > 1) ? pulses[1] : -1), 32'd14);
        check_output("reconf_pulse_c", 32'((pulses.size() > 2) ? pulses[2] : -1), 32'd18);
        check_output("reconf_ready_back", 32'(rdy_rel), 32'd10);
    endtask

    task automatic apply_stimulus_degenerate();
        send_cfg(2, 1);
        repeat (12) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check_output("div1_constant", 32'(en_out[2]), 32'd1);
        end
        send_cfg(2, 0);
        repeat (3) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check_output("div0_constant", 32'(en_out[2]), 32'd1);
        end
        send_cfg(2, 7);
        check_output("div7_transfer_edge", 32'(en_out[2]), 32'd1);
        @(negedge clk);
        check_output("div7_apply_edge", 32'(en_out[2]), 32'd1);
        repeat (6) begin
            @(negedge clk);
            check_output("div7_gap", 32'(en_out[2]), 32'd0);
        end
        @(negedge clk);
        check_output("div7_pulse", 32'(en_out[2]), 32'd1);
    endtask

    task automatic apply_stimulus_mid_reset();
        wait_pulse(0);
        send_cfg(0, 5);
        check_output("midrst_pending", 32'(cfg_ready), 32'd0);
        @(posedge clk);
        #3;
        rstb = 1'b0;
        #1;
        check_output("midrst_en_out",    32'(en_out),    32'd0);
        check_output("midrst_rstb_out",  32'(rstb_out),  32'd0);
        check_output("midrst_locked",    32'(locked),    32'd0);
        check_output("midrst_cfg_ready", 32'(cfg_ready), 32'd0);
        repeat (3) @(negedge clk);
        apply_stimulus_release("rerun");
    endtask

    task automatic apply_stimulus_out_of_range();
        int last   [3];
        int counts [3];
        int drops = 0;
        for (int k = 0; k < 3; k++) begin
            last[k]   = -1;
            counts[k] = 0;
        end
        for (int g = 0; g < 30; g++) begin
            if (cfg_ready3) break;
            @(negedge clk);
        end
        check_output("oor_ready_before", 32'(cfg_ready3), 32'd1);
        cfg_valid3 = 1'b1;
        cfg_ch3    = 2'd3;
        cfg_div3   = 16'd2;
        @(negedge clk);
        cfg_valid3 = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (!cfg_ready3) drops++;
            for (int k = 0; k < 3; k++) begin
                if (en_out3[k]) begin
                    counts[k]++;
                    if (last[k] >= 0)
                        check_output($sformatf("oor_period_ch%0d", k), 32'(ecount - last[k]), 32'd10);
                    last[k] = ecount;
                end
            end
        end
        check_output("oor_ready_stays", 32'(drops), 32'd0);
        for (int k = 0; k < 3; k++)
            check_output($sformatf("oor_pulses_ch%0d", k), 32'(counts[k]), 32'd4);
    endtask

    initial begin
        rstb       = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_div    = '0;
        cfg_valid3 = 1'b0;
        cfg_ch3    = '0;
        cfg_div3   = '0;
        repeat (3) @(negedge clk);
        check_output("reset_en_out",    32'(en_out),    32'd0);
        check_output("reset_rstb_out",  32'(rstb_out),  32'd0);
        check_output("reset_locked",    32'(locked),    32'd0);
        check_output("reset_cfg_ready", 32'(cfg_ready), 32'd0);

        $display("[TB] reset release sequence");
        apply_stimulus_release("boot");
        $display("[TB] steady state");
        apply_stimulus_steady();
        $display("[TB] reconfiguration of channel 1");
        apply_stimulus_reconfig();
        $display("[TB] degenerate ratios on channel 2");
        apply_stimulus_degenerate();
        $display("[TB] reset during operation");
        apply_stimulus_mid_reset();
        $display("[TB] out-of-range channel on three-channel build");
        apply_stimulus_out_of_range();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
